// File: rtl/adder_share_pkg.sv
// Shared constants and stage-record layout for the arbitrated adder front-end.
// A stage record is packed as {valid, id, carry, sum} with sum at the LSBs.
package adder_share_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_LAT    = 2;
    localparam int DEF_THRESH = 8;

    localparam int REC_SUM_LSB = 0;

    function automatic int rec_carry_pos(input int width);
        return width;
    endfunction

    function automatic int rec_id_lsb(input int width);
        return width + 1;
    endfunction

    function automatic int rec_valid_pos(input int width, input int idw);
        return width + 1 + idw;
    endfunction

    function automatic int rec_width(input int width, input int idw);
        return width + idw + 2;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr (wrapping) wins.
// grant is qualified by adv; grant_idx and any are valid regardless of adv.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter  int N  = DEF_NREQ,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    off;
    logic [IW:0]    pos;

    // Rotating the request vector by ptr turns the search into a fixed priority pick.
    assign req_dbl = {req, req};
    assign rot     = req_dbl[ptr +: N];

    always_comb begin
        off       = '0;
        pos       = '0;
        grant     = '0;
        grant_idx = '0;
        any       = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = (IW + 1)'(k);
            end
        end
        pos = {1'b0, ptr} + off;
        if (pos >= (IW + 1)'(N)) begin
            pos = pos - (IW + 1)'(N);
        end
        grant_idx = pos[IW-1:0];
        if (any && adv) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one registered add datapath between NREQ requesters: round-robin accept,
// LAT-deep stall-able pipeline, tagged result over valid/ready, and a thresholded bus.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter  int NREQ   = DEF_NREQ,
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int LAT    = DEF_LAT,
    parameter  int THRESH = DEF_THRESH,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic                  busy,
    inout  tri logic [WIDTH-1:0]  data
);

    localparam int          SUM_LSB   = REC_SUM_LSB;
    localparam int          CARRY_POS = rec_carry_pos(WIDTH);
    localparam int          ID_LSB    = rec_id_lsb(WIDTH);
    localparam int          VALID_POS = rec_valid_pos(WIDTH, IDW);
    localparam int          REC_W     = rec_width(WIDTH, IDW);
    localparam int unsigned THRESH_U  = THRESH;

    logic [REC_W-1:0] stage_reg [LAT];
    logic [LAT-1:0]   stage_valid;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] out_rec;
    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   ptr_next;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             any_req;
    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [WIDTH:0]   win_sum;
    logic             bus_drive;

    assign out_rec   = stage_reg[LAT-1];
    assign rsp_valid = out_rec[VALID_POS];
    assign rsp_id    = out_rec[ID_LSB +: IDW];
    assign rsp_carry = out_rec[CARRY_POS];
    assign rsp_sum   = out_rec[SUM_LSB +: WIDTH];

    // The whole pipeline moves only when the output slot is empty or being drained.
    assign adv = !rsp_valid || rsp_ready;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .adv       (adv),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    assign req_ready = grant;
    assign accept    = any_req && adv;

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_a = req_a[i*WIDTH +: WIDTH];
                win_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign win_sum = {1'b0, win_a} + {1'b0, win_b};

    // Bubbles carry an all-zero payload so idle outputs read as zero.
    always_comb begin
        rec_in = '0;
        if (accept) begin
            rec_in[VALID_POS]          = 1'b1;
            rec_in[ID_LSB +: IDW]      = grant_idx;
            rec_in[CARRY_POS]          = win_sum[WIDTH];
            rec_in[SUM_LSB +: WIDTH]   = win_sum[WIDTH-1:0];
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                stage_reg[s] <= '0;
            end
        end else if (adv) begin
            stage_reg[0] <= rec_in;
            for (int s = 1; s < LAT; s++) begin
                stage_reg[s] <= stage_reg[s-1];
            end
        end
    end

    for (genvar gi = 0; gi < LAT; gi++) begin : g_valid
        assign stage_valid[gi] = stage_reg[gi][VALID_POS];
    end

    assign busy = |stage_valid;

    // Threshold compares the truncated sum; equality leaves the bus released.
    assign bus_drive = rsp_valid && (32'(rsp_sum) > THRESH_U);
    assign data      = bus_drive ? rsp_sum : 'z;

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Arbitrated front-end that shares one registered 4-bit add datapath between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready and grants them round-robin.
- Pushes operands through a LAT-deep stall-able add pipeline and returns a tagged result over valid/ready.
- Owns the shared tri-state result bus: drives it only while presenting a result above THRESH.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/result width.
- LAT, 2, pipeline depth in cycles from accept to response (>=1).
- THRESH, 8, bus-drive threshold; bus is driven when result > THRESH (unsigned).
- IDW, $clog2(NREQ), requester-ID width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot accept; at most one bit high per cycle.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  WIDTH  (a+b) mod 2^WIDTH.
- rsp_carry  out  1  carry out of the add.
- busy  out  1  at least one operation in flight or presented.
- data  inout  WIDTH  shared result bus.

Behaviour:
- Reset: reset rst, asynchronous, active-high; clock clk.
  - Reset clears all pipeline valid bits, rsp_valid, rsp_id, rsp_sum, rsp_carry and busy to 0.
  - Reset sets the round-robin pointer to 0 and releases data to Z.
  - Reset mid-operation drops all in-flight results silently.
- Advance enable: adv = !rsp_valid || rsp_ready. When adv=0, every pipeline stage holds its contents and req_ready is all 0.
- Arbitration:
  - Search starts at pointer p and wraps modulo NREQ. The first i with req_valid[i]=1 wins.
  - req_ready[i] = win[i] & adv. req_ready is combinational from req_valid, p and rsp_ready; there is no path from req_ready back to req_valid.
  - On accept of winner w, p <= (w+1) mod NREQ. With no accept, p holds.
- Pipeline:
  - Stage 0 captures {id, a+b with carry, valid} on accept. With adv=1 and no accept, a bubble (valid=0) enters.
  - Stage LAT-1 is the output register.
  - Accept at edge T gives rsp_valid=1 after edge T+LAT-1, i.e. the result is visible in the cycle after edge T+LAT-1 when the pipeline is unstalled.
  - Full throughput: one accept per cycle while rsp_ready=1.
- Arithmetic: a WIDTH+1-bit add. rsp_sum takes the low WIDTH bits and rsp_carry takes the MSB.
- Response:
  - rsp_id, rsp_sum and rsp_carry stay stable while rsp_valid=1 and rsp_ready=0.
  - A transfer completes on an edge with rsp_valid && rsp_ready.
- Bus: data = (rsp_valid && rsp_sum > THRESH) ? rsp_sum : Z. The comparison is on the truncated sum. Exactly equal to THRESH gives Z.
- busy: OR of all stage valid bits.
- Boundaries:
  - All requesters valid: strict rotation 0,1,2,3,0...
  - Single requester holding valid: accepted every cycle.
  - Request dropped before accept: no state change. Requesters may withdraw; the controller requires nothing of them.
  - Simultaneous response pop and new accept: both occur (adv=1).

Decomposition:
- Package adder_share_pkg holds:
  - default WIDTH/NREQ/LAT/THRESH constants;
  - the stage-record layout {valid, id, carry, sum} as localparam field offsets/width.
- Sub-module rr_arbiter (params N; ports req, ptr, adv -> grant one-hot, grant_idx, any) is natural and unit-testable.

Test Plan:
1. Reset mid-flight: accept a=3,b=4 from req0, assert rst the next cycle -> rsp_valid never rises, busy=0, data=Z, and the next grant goes to req0.
2. Latency/carry: LAT=2, req2 sends a=9,b=8, rsp_ready=1 -> rsp_valid 2 cycles after accept with id=2, sum=1, carry=1, data=Z.
3. Bus drive: req1 sends a=5,b=4 -> sum=9, data=9 while rsp_valid. Then req1 sends a=4,b=4 -> sum=8, data=Z (boundary).
4. Round-robin fairness: all four valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and responses in the same id order with no bubbles.
5. Backpressure: hold rsp_ready=0 for 3 cycles with a full pipeline -> req_ready=0 and rsp outputs unchanged. On release, results drain in order with none lost or duplicated.
6. Sparse requests: only req3 valid, then only req1 -> req3 is accepted each cycle and the pointer wraps to 0; req1 is then accepted on its first valid cycle.
